// File: rtl/tl_port_scheduler_pkg.sv
// Shared constants for the transaction-layer port scheduler: FSM encodings,
// default widths and the location of the destination field in a word.
package tl_pkg;

    localparam int TL_DATA_W    = 12;
    localparam int TL_OCC_W     = 4;
    localparam int TL_TH_W      = 3;
    localparam int TL_CNT_W     = 5;
    localparam int TL_NUM_PORTS = 4;
    localparam int TL_DEF_ALTO  = 6;
    localparam int TL_DEF_BAJO  = 1;

    // Destination occupies the top TL_DEST_W bits of each word.
    localparam int TL_DEST_W    = 2;

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

endpackage

// File: rtl/tl_port_watermark.sv
// One port's backpressure tracker: effective occupancy (FIFO level plus the
// push still in flight) against the high/low thresholds, with hysteresis.
module tl_port_watermark
    import tl_pkg::*;
#(
    parameter int OCC_W = TL_OCC_W,
    parameter int TH_W  = TL_TH_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OCC_W-1:0] occ,
    input  logic             pushing,
    input  logic [TH_W-1:0]  alto,
    input  logic [TH_W-1:0]  bajo,
    output logic             at_high,
    output logic             blocked
);

    localparam int CW = (OCC_W + 1 > TH_W) ? OCC_W + 1 : TH_W;

    logic [OCC_W:0] eocc;
    logic [CW-1:0]  eocc_w, alto_w, bajo_w;
    logic           at_low;

    assign eocc    = {1'b0, occ} + {{OCC_W{1'b0}}, pushing};
    assign eocc_w  = CW'(eocc);
    assign alto_w  = CW'(alto);
    assign bajo_w  = CW'(bajo);
    assign at_high = (eocc_w >= alto_w);
    assign at_low  = (eocc_w <= bajo_w);

    // Between the two marks the previous decision is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        blocked <= 1'b0;
        else if (at_high) blocked <= 1'b1;
        else if (at_low)  blocked <= 1'b0;
    end

endmodule

// File: rtl/tl_port_scheduler.sv
// Pops words from the show-ahead input FIFO and steers each to one of four
// port FIFOs by its dest field, with watermark backpressure and push counters.
module tl_port_scheduler
    import tl_pkg::*;
#(
    parameter int DATA_W   = TL_DATA_W,
    parameter int OCC_W    = TL_OCC_W,
    parameter int TH_W     = TL_TH_W,
    parameter int CNT_W    = TL_CNT_W,
    parameter int DEF_ALTO = TL_DEF_ALTO,
    parameter int DEF_BAJO = TL_DEF_BAJO
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              init,
    input  logic [TH_W-1:0]                   Umbral_alto,
    input  logic [TH_W-1:0]                   Umbral_bajo,
    input  logic                              in_empty,
    input  logic [DATA_W-1:0]                 in_data,
    output logic                              in_pop,
    input  logic [TL_NUM_PORTS*OCC_W-1:0]     occ,
    output logic [TL_NUM_PORTS-1:0]           out_push,
    output logic [DATA_W-1:0]                 out_data,
    input  logic                              req,
    input  logic [2:0]                        idx,
    output logic [CNT_W-1:0]                  counterOut,
    output logic                              counterValid,
    output logic [1:0]                        state_o
);

    localparam int NP = TL_NUM_PORTS;

    logic [1:0]                  state, state_nxt;
    logic [TH_W-1:0]             alto, bajo;
    logic [NP-1:0][OCC_W-1:0]    occ_p;
    logic [NP-1:0]               at_high, blocked;
    logic [NP-1:0][CNT_W-1:0]    cnt;
    logic [TL_DEST_W-1:0]        dest;

    assign occ_p   = occ;
    assign dest    = in_data[DATA_W-1 -: TL_DEST_W];
    assign state_o = state;

    // Head-of-line: a stalled head holds every port; the same-cycle crossing
    // term stops the pop that would overshoot before blocked can register.
    assign in_pop = (state == ST_ACTIVE) && !in_empty &&
                    !blocked[dest] && !at_high[dest];

    for (genvar g = 0; g < NP; g++) begin : g_wm
        tl_port_watermark #(
            .OCC_W (OCC_W),
            .TH_W  (TH_W)
        ) u_wm (
            .clk     (clk),
            .reset   (reset),
            .occ     (occ_p[g]),
            .pushing (out_push[g]),
            .alto    (alto),
            .bajo    (bajo),
            .at_high (at_high[g]),
            .blocked (blocked[g])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_RESET;
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE:   if (!in_empty) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (in_empty)  state_nxt = ST_IDLE;
        endcase
        if (init) state_nxt = ST_INIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RESET;
        else       state <= state_nxt;
    end

    // Low mark is forced strictly below the high mark so hysteresis never inverts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alto <= TH_W'(DEF_ALTO);
            bajo <= TH_W'(DEF_BAJO);
        end else if (init) begin
            alto <= Umbral_alto;
            if (Umbral_bajo < Umbral_alto) bajo <= Umbral_bajo;
            else if (Umbral_alto == '0)    bajo <= '0;
            else                           bajo <= Umbral_alto - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_push <= '0;
            out_data <= '0;
        end else begin
            out_push <= '0;
            if (in_pop) begin
                out_push[dest] <= 1'b1;
                out_data       <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int p = 0; p < NP; p++)
                if (out_push[p]) cnt[p] <= cnt[p] + 1'b1;
        end
    end

    // Reads sample the counter before this edge's increment lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counterValid <= 1'b0;
            counterOut   <= '0;
        end else begin
            counterValid <= req;
            if (req) counterOut <= idx[2] ? '0 : cnt[idx[1:0]];
        end
    end

endmodule

// File: tb/tb_tl_port_scheduler.sv
// Directed scenarios followed by a randomized run, all checked every cycle
// against a word-queue reference model of the scheduler.
module tb_tl_port_scheduler;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0;
    logic [2:0]  Umbral_alto = '0;
    logic [2:0]  Umbral_bajo = '0;
    logic        in_empty = 1'b1;
    logic [11:0] in_data = '0;
    logic        in_pop;
    logic [15:0] occ = '0;
    logic [3:0]  out_push;
    logic [11:0] out_data;
    logic        req = 1'b0;
    logic [2:0]  idx = '0;
    logic [4:0]  counterOut;
    logic        counterValid;
    logic [1:0]  state_o;

    tl_port_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .Umbral_alto  (Umbral_alto),
        .Umbral_bajo  (Umbral_bajo),
        .in_empty     (in_empty),
        .in_data      (in_data),
        .in_pop       (in_pop),
        .occ          (occ),
        .out_push     (out_push),
        .out_data     (out_data),
        .req          (req),
        .idx          (idx),
        .counterOut   (counterOut),
        .counterValid (counterValid),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: states 0=RESET 1=INIT 2=IDLE 3=ACTIVE, push as port number or -1.
    int          m_state, m_alto, m_bajo, m_push, m_cv, m_co;
    logic [11:0] m_data;
    bit          m_blk[NP];
    int          m_cnt[NP];
    int          m_occ[NP];
    logic [11:0] q[$];
    int          vectors = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_alto = 6; m_bajo = 1; m_push = -1;
        m_data = '0; m_cv = 0; m_co = 0;
        for (int p = 0; p < NP; p++) begin
            m_blk[p] = 1'b0;
            m_cnt[p] = 0;
        end
    endtask

    task automatic tick();
        int dest;
        int eocc[NP];
        bit pop;
        in_empty = (q.size() == 0);
        in_data  = in_empty ? 12'h000 : q[0];
        for (int p = 0; p < NP; p++) occ[p*4 +: 4] = 4'(m_occ[p]);
        #1;
        dest = int'(in_data[11:10]);
        for (int p = 0; p < NP; p++) eocc[p] = m_occ[p] + ((m_push == p) ? 1 : 0);
        pop = (m_state == 3) && !in_empty && !m_blk[dest] && (eocc[dest] < m_alto);
        chk("in_pop", in_pop, pop);
        m_cv = req;
        if (req) m_co = (idx < 4) ? m_cnt[idx] : 0;
        if (m_push >= 0) m_cnt[m_push] = (m_cnt[m_push] + 1) % 32;
        for (int p = 0; p < NP; p++) begin
            if (eocc[p] >= m_alto)      m_blk[p] = 1'b1;
            else if (eocc[p] <= m_bajo) m_blk[p] = 1'b0;
        end
        m_push = pop ? dest : -1;
        if (pop) begin
            m_data = in_data;
            void'(q.pop_front());
        end
        if (init) begin
            m_state = 1;
            m_alto  = int'(Umbral_alto);
            if (Umbral_bajo < Umbral_alto) m_bajo = int'(Umbral_bajo);
            else                           m_bajo = (m_alto == 0) ? 0 : m_alto - 1;
        end else begin
            case (m_state)
                1: m_state = 2;
                2: if (!in_empty) m_state = 3;
                3: if (in_empty) m_state = 2;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        init = 1'b0;
        req  = 1'b0;
        chk("state", state_o, m_state);
        chk("out_push", out_push, (m_push >= 0) ? (1 << m_push) : 0);
        if (m_push >= 0) chk("out_data", out_data, m_data);
        chk("cnt_valid", counterValid, m_cv);
        if (m_cv) chk("cnt_out", counterOut, m_co);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input int i);
        req = 1'b1;
        idx = 3'(i);
        tick();
    endtask

    task automatic do_init(input int a, input int b);
        Umbral_alto = 3'(a);
        Umbral_bajo = 3'(b);
        init = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        m_reset();
        q.delete();
        chk("rst_state", state_o, 0);
        chk("rst_push", out_push, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cv", counterValid, 0);
        chk("rst_co", counterOut, 0);
        chk("rst_pop", in_pop, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < NP; p++) m_occ[p] = 0;
        #1;
        do_reset();

        // 1: no pops before init; init goes INIT then IDLE
        q.push_back(12'h00F);
        run(2);
        do_init(6, 0);
        chk("t1_init", state_o, 1);
        tick();
        chk("t1_idle", state_o, 2);
        chk("t1_nopop", in_pop, 0);

        // 2: three dest-0 words
        q.push_back(12'h014);
        q.push_back(12'h019);
        run(6);
        rd(0);
        chk("t2_cnt0", counterOut, 3);

        // 3: dest 2, 3, 3
        q.push_back(12'hAFF);
        q.push_back(12'hFFF);
        q.push_back(12'hCFF);
        run(6);
        rd(3);
        chk("t3_cnt3", counterOut, 2);
        chk("t3_valid", counterValid, 1);
        rd(5);
        chk("t3_none", counterOut, 0);

        // 4: occupancy 5 plus one push reaches alto=6 and stalls the head
        m_occ[0] = 5;
        q.push_back(12'h001);
        q.push_back(12'h002);
        q.push_back(12'h003);
        run(5);
        chk("t4_stall", out_push, 0);
        chk("t4_nopop", in_pop, 0);
        m_occ[0] = 0;
        run(6);
        rd(0);
        chk("t4_cnt0", counterOut, 6);

        // 5: bajo 7 with alto 4 latches as 3; blocked clears at occupancy 3
        do_init(4, 7);
        tick();
        m_occ[2] = 4;
        q.push_back(12'h801);
        q.push_back(12'h802);
        run(3);
        m_occ[2] = 3;
        run(2);
        chk("t5_resume", out_push, 4'b0100);
        m_occ[2] = 0;
        run(4);
        Umbral_alto = 3'd6;
        Umbral_bajo = 3'd0;
        for (int i = 0; i < 8; i++) q.push_back(12'hC10 + 12'(i));
        run(3);
        init = 1'b1;
        tick();
        chk("t5_init", state_o, 1);
        chk("t5_nopop", in_pop, 0);
        tick();
        chk("t5_idle", state_o, 2);
        tick();
        chk("t5_active", state_o, 3);
        run(8);

        // 6: 33 pushes wrap counter[1]; reset mid-stream
        for (int i = 0; i < 33; i++) q.push_back(12'h400 | 12'(i));
        run(36);
        rd(1);
        chk("t6_wrap", counterOut, 1);
        for (int i = 0; i < 6; i++) q.push_back(12'h500 + 12'(i));
        run(3);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(i);
            chk("t6_cnt_clr", counterOut, 0);
        end

        // 7: randomized traffic, occupancy, reads and occasional re-init
        do_init($urandom_range(1, 7), $urandom_range(0, 7));
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0 || q.size() < 2) q.push_back(12'($urandom));
            for (int p = 0; p < NP; p++)
                m_occ[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 2);
            req = ($urandom_range(0, 3) == 0);
            idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) begin
                init = 1'b1;
                Umbral_alto = 3'($urandom_range(1, 7));
                Umbral_bajo = 3'($urandom_range(0, 7));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
